// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stalls and branch flushes, and a saturating load-use stall counter.
module id_ex_hazard_reg #(
   parameter int DW = 32,
   parameter int RW = 5,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    id_aluop,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic          id_memtoreg,
   input  logic          id_alusrc,
   input  logic          id_regdst,
   input  logic          id_valid,
   input  logic          id_uses_rt,
   input  logic [DW-1:0] id_rd1,
   input  logic [DW-1:0] id_rd2,
   input  logic [DW-1:0] id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic          flush,
   output logic          hz_sel,
   output logic          pc_write,
   output logic          ifid_write,
   output logic [1:0]    ex_aluop,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          ex_memtoreg,
   output logic          ex_alusrc,
   output logic          ex_regdst,
   output logic          ex_valid,
   output logic [DW-1:0] ex_rd1,
   output logic [DW-1:0] ex_rd2,
   output logic [DW-1:0] ex_imm,
   output logic [RW-1:0] ex_rs,
   output logic [RW-1:0] ex_rt,
   output logic [RW-1:0] ex_rd,
   output logic [CW-1:0] stall_cnt
);

   logic [1:0]    ex_aluop_d, ex_aluop_q;
   logic [5:0]    ex_ctrl_d, ex_ctrl_q;
   logic          ex_valid_d, ex_valid_q;
   logic [DW-1:0] ex_rd1_d, ex_rd1_q, ex_rd2_d, ex_rd2_q, ex_imm_d, ex_imm_q;
   logic [RW-1:0] ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q, ex_rd_d, ex_rd_q;
   logic [CW-1:0] stall_cnt_d, stall_cnt_q;
   logic          lu_s, hz_sel_s;

   // Load-use detection against the instruction currently held in EX
   always_comb begin
      lu_s = ex_valid_q & ex_ctrl_q[4] & (ex_rt_q != {RW{1'b0}}) & id_valid &
             ((ex_rt_q == id_rs) | (id_uses_rt & (ex_rt_q == id_rt)));
      hz_sel_s = lu_s | flush;
   end

   // Next EX contents: controls are zeroed on a bubble, data always follows ID
   always_comb begin
      ex_rd1_d = id_rd1;
      ex_rd2_d = id_rd2;
      ex_imm_d = id_imm;
      ex_rs_d  = id_rs;
      ex_rt_d  = id_rt;
      ex_rd_d  = id_rd;
      if (hz_sel_s) begin
         // Forced locally too, so a mis-wired bubble mux cannot leak an ALUOp
         ex_aluop_d = 2'b00;
         ex_ctrl_d  = 6'b000000;
         ex_valid_d = 1'b0;
      end else begin
         ex_aluop_d = id_aluop;
         ex_ctrl_d  = {id_regwrite, id_memread, id_memwrite,
                       id_memtoreg, id_alusrc, id_regdst};
         ex_valid_d = id_valid;
      end
   end

   // Saturating count of cycles actually stalled (a flush overrides the stall)
   always_comb begin
      if (lu_s & ~flush & (stall_cnt_q != {CW{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Pipeline register and counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_aluop_q  <= 2'b00;
         ex_ctrl_q   <= 6'b000000;
         ex_valid_q  <= 1'b0;
         ex_rd1_q    <= {DW{1'b0}};
         ex_rd2_q    <= {DW{1'b0}};
         ex_imm_q    <= {DW{1'b0}};
         ex_rs_q     <= {RW{1'b0}};
         ex_rt_q     <= {RW{1'b0}};
         ex_rd_q     <= {RW{1'b0}};
         stall_cnt_q <= {CW{1'b0}};
      end else begin
         ex_aluop_q  <= ex_aluop_d;
         ex_ctrl_q   <= ex_ctrl_d;
         ex_valid_q  <= ex_valid_d;
         ex_rd1_q    <= ex_rd1_d;
         ex_rd2_q    <= ex_rd2_d;
         ex_imm_q    <= ex_imm_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_rd_q     <= ex_rd_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz_sel      = hz_sel_s;
   assign pc_write    = ~lu_s | flush;
   assign ifid_write  = ~lu_s | flush;
   assign ex_aluop    = ex_aluop_q;
   assign ex_regwrite = ex_ctrl_q[5];
   assign ex_memread  = ex_ctrl_q[4];
   assign ex_memwrite = ex_ctrl_q[3];
   assign ex_memtoreg = ex_ctrl_q[2];
   assign ex_alusrc   = ex_ctrl_q[1];
   assign ex_regdst   = ex_ctrl_q[0];
   assign ex_valid    = ex_valid_q;
   assign ex_rd1      = ex_rd1_q;
   assign ex_rd2      = ex_rd2_q;
   assign ex_imm      = ex_imm_q;
   assign ex_rs       = ex_rs_q;
   assign ex_rt       = ex_rt_q;
   assign ex_rd       = ex_rd_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/id_ex_hazard_reg.md
# id_ex_hazard_reg

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. Sits between decode and execute:
- Drives the select line of the ALUOp bubble mux (mux input 0 = control-unit ALUOp, input 1 = 2'b00).
- Captures the mux output together with the remaining decode controls and operands.
- Inserts one-cycle bubbles on load-use hazards and on branch flushes from EX.
- Keeps a saturating stall counter for performance debug.

## Interface
Parameters:
- DW, 32, datapath width
- RW, 5, register index width
- CW, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_aluop  in  2  ALUOp from the ALUOp bubble mux output
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst  in  1 each  decode controls
- id_valid  in  1  ID holds a real instruction
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, store, branch)
- id_rd1, id_rd2, id_imm  in  DW each  register operands, sign-extended immediate
- id_rs, id_rt, id_rd  in  RW each  register indices
- flush  in  1  branch taken, resolved in EX
- hz_sel  out  1  bubble select to the ALUOp mux (1 = bubble)
- pc_write  out  1  PC write enable
- ifid_write  out  1  IF/ID write enable
- ex_aluop  out  2  registered ALUOp
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst  out  1 each  registered controls
- ex_valid  out  1  EX holds a real instruction
- ex_rd1, ex_rd2, ex_imm  out  DW each  registered operands
- ex_rs, ex_rt, ex_rd  out  RW each  registered indices
- stall_cnt  out  CW  saturating count of load-use stall cycles

## Operation
- **Hazard detect (combinational):**
  - `lu = ex_valid & ex_memread & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))`.
- **Control outputs:**
  - `hz_sel = lu | flush`.
  - `pc_write = ~lu | flush`: flush wins, so the PC loads the branch target.
  - `ifid_write = ~lu | flush`.
- **Register update, each posedge:**
  - If `hz_sel`: all six 1-bit ex_* controls, ex_aluop and ex_valid load 0. Data and index fields load the ID values (don't-care, but deterministic).
  - Otherwise every ex_* field loads its id_* counterpart.
  - ex_aluop always loads id_aluop. When hz_sel = 1 the mux already supplies 2'b00; the register also forces 0 internally so a mis-wired mux cannot leak an ALUOp.
- **Stall counter:**
  - Increments when `lu & ~flush`.
  - Holds at all-ones; never wraps.
- **Precedence and boundary cases:**
  - flush and lu together: flush wins (bubble, pc_write = 1, ifid_write = 1, no count).
  - A load with rt = $0 never stalls.
  - A bubble in EX (ex_valid = 0) never causes a stall.
  - A stall lasts exactly one cycle. The next cycle EX holds the bubble (ex_memread = 0), so lu drops and the dependent instruction advances. Its operand then comes from MEM/WB forwarding, which is outside this block.
  - id_valid = 0: no stall.

## Timing
- Register latency: 1 cycle, ID to EX.
- hz_sel, pc_write and ifid_write are combinational from registered EX fields and current ID inputs. They are valid within the same cycle and must meet setup at the PC and IF/ID registers.
- Reset (rst_n low, async): all ex_* outputs 0, ex_valid 0, stall_cnt 0.
  - Outputs during and immediately after reset: hz_sel 0, pc_write 1, ifid_write 1.
- Reset asserted mid-stall clears EX immediately. The stall condition disappears in the same cycle.
- Release of rst_n is synchronous in effect: the first capture happens on the first posedge with rst_n high.

## Test plan
- **Reset:** drive random ID inputs, hold rst_n low 3 cycles → all ex_* = 0, stall_cnt = 0, pc_write = 1, hz_sel = 0.
- **Pass-through:** ID = add (aluop 2'b10, regwrite 1, rs 1, rt 2, rd 3, valid 1), no hazard → next cycle ex_aluop = 2'b10, ex_rd = 3, ex_valid = 1, hz_sel stays 0.
- **Load-use:** `lw $5` in EX, `add $6,$5,$7` in ID → hz_sel = 1, pc_write = 0, ifid_write = 0 for exactly 1 cycle, stall_cnt 0→1.
  - Next cycle EX holds a bubble (ex_valid 0, ex_aluop 0).
  - The add enters EX one cycle later.
- **Non-hazards:** `lw $0` followed by a use of $0 → no stall. `lw $5` followed by `addi` with rt = $5 and id_uses_rt = 0 → no stall.
- **Flush with concurrent load-use:** flush = 1 and lu = 1 in the same cycle → hz_sel 1, pc_write 1, ifid_write 1, stall_cnt unchanged, EX bubble next cycle.
- **Saturation and async reset:** preload stall_cnt to 16'hFFFE via repeated load-use pairs (or force) → two more stalls leave it at 16'hFFFF. Asserting rst_n mid-stall clears the count and EX asynchronously.
